// File: rtl/nlc_pkg.sv
// Shared constants, state encoding and helpers for the coefficient loader.
package nlc_pkg;

    localparam int SECTIONS = 4;
    localparam int ORDER    = 10;
    localparam int WPS      = ORDER + 3;
    localparam int NWORDS   = 1 + SECTIONS * WPS;
    localparam int NBANK    = SECTIONS * WPS;
    localparam int CNT_W    = 6;
    localparam int LIMIT_W  = 20;

    // Field offsets inside one section block
    localparam int F_RSTD   = 0;
    localparam int F_NMEAN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2
    } nlc_state_e;

    // Offset of polynomial coefficient n (coeff_ORDER comes first)
    function automatic int F_C(input int n);
        return 2 + ORDER - n;
    endfunction

    // Block index of section s (section 4 is streamed first)
    function automatic int BLK(input int s);
        return 4 - s;
    endfunction

    // Running checksum: plain modulo-2^32 sum
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] w);
        return acc + w;
    endfunction

endpackage

// File: rtl/nlc_bank_reg.sv
// Shadow/active register pair: shadow is written word by word, active is
// replaced as a whole on the commit strobe so the engine never sees a mix.
module nlc_bank_reg
    import nlc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [CNT_W-1:0]       wr_idx,
    input  logic [31:0]            wr_data,
    input  logic                   commit,
    output logic [NBANK*32-1:0]    active
);

    logic [31:0] shadow_r [NBANK];
    logic [31:0] active_r [NBANK];

    // Shadow bank: one word captured per accepted payload beat
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANK; i++) begin
            if (reset) begin
                shadow_r[i] <= 32'd0;
            end else if (wr_en && (wr_idx == CNT_W'(i))) begin
                shadow_r[i] <= wr_data;
            end else begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Active bank: whole-bank copy from shadow on commit only
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANK; i++) begin
            if (reset) begin
                active_r[i] <= 32'd0;
            end else if (commit) begin
                active_r[i] <= shadow_r[i];
            end else begin
                active_r[i] <= active_r[i];
            end
        end
    end

    // Flatten the active bank onto the output bus
    always_comb begin
        active = '0;
        for (int i = 0; i < NBANK; i++) begin
            active[i*32 +: 32] = active_r[i];
        end
    end

endmodule

// File: rtl/nlc_coeff_loader.sv
// Streaming loader: receives section limit plus section parameters, verifies
// the trailing checksum, and commits the bank while the engine is idle.
module nlc_coeff_loader
    import nlc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [31:0]            cfg_data_i,
    input  logic                   cfg_abort_i,
    input  logic                   nlc_idle_i,
    output logic [LIMIT_W-1:0]     section_limit_o,
    output logic [NBANK*32-1:0]    bank_o,
    output logic                   bank_valid_o,
    output logic                   commit_o,
    output logic                   err_o
);

    nlc_state_e         state_r, state_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [31:0]        sum_r, sum_s;
    logic [LIMIT_W-1:0] shadow_limit_r, shadow_limit_s;
    logic [LIMIT_W-1:0] active_limit_r;
    logic               bank_valid_r;
    logic               commit_r;
    logic               err_r;
    logic               ready_s;
    logic               beat_s;
    logic               wr_en_s;
    logic [CNT_W-1:0]   wr_idx_s;
    logic               commit_s;
    logic               err_s;

    // Ready is low during reset and while a verified bank waits for commit
    always_comb begin
        ready_s = (~reset) & (state_r != ST_PENDING);
        beat_s  = cfg_valid_i & ready_s;
    end

    // Next-state, counter, checksum and bank-write control
    always_comb begin
        state_s        = state_r;
        count_s        = count_r;
        sum_s          = sum_r;
        shadow_limit_s = shadow_limit_r;
        wr_en_s        = 1'b0;
        wr_idx_s       = count_r - 6'd1;
        commit_s       = 1'b0;
        err_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (beat_s) begin
                    shadow_limit_s = cfg_data_i[LIMIT_W-1:0];
                    count_s        = 6'd1;
                    sum_s          = cfg_data_i;
                    state_s        = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_abort_i) begin
                    count_s = 6'd0;
                    sum_s   = 32'd0;
                    state_s = ST_IDLE;
                end else if (beat_s) begin
                    if (count_r == CNT_W'(NWORDS)) begin
                        // This beat carries the checksum itself
                        count_s = 6'd0;
                        sum_s   = 32'd0;
                        if (cfg_data_i == sum_r) begin
                            state_s = ST_PENDING;
                        end else begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        wr_en_s = 1'b1;
                        count_s = count_r + 6'd1;
                        sum_s   = csum_add(sum_r, cfg_data_i);
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_PENDING: begin
                if (cfg_abort_i) begin
                    state_s = ST_IDLE;
                end else if (nlc_idle_i) begin
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_PENDING;
                end
            end
            default: begin
                count_s = 6'd0;
                sum_s   = 32'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, checksum, limit and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            count_r        <= 6'd0;
            sum_r          <= 32'd0;
            shadow_limit_r <= 20'd0;
            active_limit_r <= 20'd0;
            bank_valid_r   <= 1'b0;
            commit_r       <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r        <= state_s;
            count_r        <= count_s;
            sum_r          <= sum_s;
            shadow_limit_r <= shadow_limit_s;
            active_limit_r <= commit_s ? shadow_limit_r : active_limit_r;
            bank_valid_r   <= bank_valid_r | commit_s;
            commit_r       <= commit_s;
            err_r          <= err_s;
        end
    end

    nlc_bank_reg u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_s),
        .wr_data (cfg_data_i),
        .commit  (commit_s),
        .active  (bank_o)
    );

    assign cfg_ready_o     = ready_s;
    assign section_limit_o = active_limit_r;
    assign bank_valid_o    = bank_valid_r;
    assign commit_o        = commit_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_nlc_coeff_loader.sv
// Directed bench for nlc_coeff_loader: loads with known word patterns
// (word i = base+i+1), checksum errors, commit stall, abort and reset.
module tb_nlc_coeff_loader;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [31:0]   cfg_data_i;
    logic          cfg_abort_i;
    logic          nlc_idle_i;
    logic [19:0]   section_limit_o;
    logic [1663:0] bank_o;
    logic          bank_valid_o;
    logic          commit_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;
    int commit_cnt = 0;
    int err_cnt = 0;
    int c0;
    int e0;
    int stall_ok;

    nlc_coeff_loader dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_data_i      (cfg_data_i),
        .cfg_abort_i     (cfg_abort_i),
        .nlc_idle_i      (nlc_idle_i),
        .section_limit_o (section_limit_o),
        .bank_o          (bank_o),
        .bank_valid_o    (bank_valid_o),
        .commit_o        (commit_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    // Count output pulses, one per high cycle
    always @(negedge clk) begin
        if (commit_o) commit_cnt <= commit_cnt + 1;
        if (err_o)    err_cnt    <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int base, input int i);
        return 32'(base + i + 1);
    endfunction

    function automatic logic [31:0] csum_of(input int base);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 53; i++) s = s + word_of(base, i);
        return s;
    endfunction

    function automatic logic [31:0] bank_word(input int j);
        return bank_o[32*j +: 32];
    endfunction

    // Present one word at a negedge and hold it until it has been accepted
    task automatic send_word(input logic [31:0] d, input bit gaps);
        int n;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            cfg_valid_i = 1'b0;
            @(negedge clk);
        end
        cfg_valid_i = 1'b1;
        cfg_data_i  = d;
        n = 0;
        while (!cfg_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(cfg_ready_o), 32'd1);
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic send_range(input int base, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) send_word(word_of(base, i), gaps);
    endtask

    task automatic load(input int base, input logic [31:0] delta, input bit gaps);
        send_range(base, 0, 52, gaps);
        send_word(csum_of(base) + delta, gaps);
    endtask

    task automatic check_active(input string tag, input int base);
        chk({tag, "_limit"},  32'(section_limit_o), 32'(base + 1));
        chk({tag, "_w0"},     bank_word(0),  32'(base + 2));
        chk({tag, "_w25"},    bank_word(25), 32'(base + 27));
        chk({tag, "_w51"},    bank_word(51), 32'(base + 53));
        chk({tag, "_valid"},  32'(bank_valid_o), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_data_i  = 32'd0;
        cfg_abort_i = 1'b0;
        nlc_idle_i  = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(cfg_ready_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(cfg_ready_o), 32'd1);
        chk("rst_valid",  32'(bank_valid_o), 32'd0);
        chk("rst_limit",  32'(section_limit_o), 32'd0);
        chk("rst_bank",   32'(bank_o == '0), 32'd1);
        chk("rst_commit", 32'(commit_o), 32'd0);
        chk("rst_err",    32'(err_o), 32'd0);
        @(negedge clk);

        // Bad checksum (1430): one error pulse, nothing committed
        c0 = commit_cnt; e0 = err_cnt;
        load(0, 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(negedge clk);
        chk("bad_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("bad_no_commit",  32'(commit_cnt - c0), 32'd0);
        chk("bad_valid",      32'(bank_valid_o), 32'd0);
        chk("bad_bank_zero",  32'(bank_o == '0), 32'd1);
        chk("bad_ready",      32'(cfg_ready_o), 32'd1);

        // Good load of words 1..53, checksum 1431
        chk("csum_1431", csum_of(0), 32'd1431);
        c0 = commit_cnt; e0 = err_cnt;
        load(0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("good_commit", 32'(commit_cnt - c0), 32'd1);
        chk("good_no_err", 32'(err_cnt - e0), 32'd0);
        check_active("good", 0);

        // Engine busy: verified bank waits; the next word is held meanwhile
        nlc_idle_i = 1'b0;
        c0 = commit_cnt;
        load(300, 32'd0, 1'b0);
        cfg_valid_i = 1'b1;
        cfg_data_i  = word_of(6, 0);
        stall_ok = 1;
        for (int i = 0; i < 20; i++) begin
            if (cfg_ready_o !== 1'b0 || section_limit_o !== 20'd1 ||
                bank_word(0) !== 32'd2 || commit_o !== 1'b0) stall_ok = 0;
            @(negedge clk);
        end
        chk("stall_hold", 32'(stall_ok), 32'd1);
        chk("stall_no_commit", 32'(commit_cnt - c0), 32'd0);
        nlc_idle_i = 1'b1;
        send_range(6, 0, 0, 1'b0);
        chk("stall_commit", 32'(commit_cnt - c0), 32'd1);
        check_active("stall", 300);
        send_range(6, 1, 52, 1'b0);
        send_word(csum_of(6), 1'b0);
        repeat (5) @(negedge clk);
        chk("held_commit", 32'(commit_cnt - c0), 32'd2);
        check_active("held", 6);

        // Abort together with the 10th beat, then a full load of 100+k
        c0 = commit_cnt;
        send_range(500, 0, 8, 1'b0);
        cfg_valid_i = 1'b1;
        cfg_data_i  = word_of(500, 9);
        cfg_abort_i = 1'b1;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        cfg_abort_i = 1'b0;
        load(100, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("abort_commit", 32'(commit_cnt - c0), 32'd1);
        check_active("abort", 100);

        // Abort while pending discards the verified bank
        nlc_idle_i = 1'b0;
        c0 = commit_cnt;
        load(700, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        cfg_abort_i = 1'b1;
        @(negedge clk);
        cfg_abort_i = 1'b0;
        nlc_idle_i  = 1'b1;
        repeat (5) @(negedge clk);
        chk("pabort_no_commit", 32'(commit_cnt - c0), 32'd0);
        chk("pabort_ready", 32'(cfg_ready_o), 32'd1);
        check_active("pabort", 100);

        // Random gaps in valid: same result as back-to-back
        c0 = commit_cnt;
        load(0, 32'd0, 1'b1);
        repeat (5) @(negedge clk);
        chk("gaps_commit", 32'(commit_cnt - c0), 32'd1);
        check_active("gaps", 0);

        // Reset in the middle of a second load clears everything
        send_range(100, 0, 29, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_ready", 32'(cfg_ready_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(cfg_ready_o), 32'd1);
        chk("mid_rst_valid", 32'(bank_valid_o), 32'd0);
        chk("mid_rst_limit", 32'(section_limit_o), 32'd0);
        chk("mid_rst_bank",  32'(bank_o == '0), 32'd1);
        chk("mid_rst_commit", 32'(commit_o), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
